// File: rtl/ro_puf_bank.sv
// ro_puf_bank: a bank of emulated ring oscillators with an arbiter-style PUF readout.
// Every ring is stepped by its own clock-enable divider inside the single clk domain.
// A measurement FSM counts rising edges of two chosen rings over a fixed window and
// compares the two counts to produce a one-bit response.
module ro_puf_bank #(
    parameter int NUM_RO   = 16,
    parameter int STAGES   = 15,
    parameter int BASE_DIV = 10,
    parameter int DIV_STEP = 1,
    parameter int WINDOW   = 4096,
    parameter int CNT_W    = 16,
    parameter int SEL_W    = (NUM_RO > 1) ? $clog2(NUM_RO) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEL_W-1:0]  sel_a,
    input  logic [SEL_W-1:0]  sel_b,
    output logic              busy,
    output logic              done,
    output logic              response,
    output logic              tie,
    output logic              err,
    output logic [CNT_W-1:0]  count_a,
    output logic [CNT_W-1:0]  count_b,
    output logic [NUM_RO-1:0] ro_out
);

    localparam int DIV_MAX = BASE_DIV + (NUM_RO - 1) * DIV_STEP;
    localparam int DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam int WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int NUM_CH  = 2 ** SEL_W;

    localparam logic [SEL_W:0]   NUM_RO_V = (SEL_W + 1)'(NUM_RO);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Alternating pattern with bit k = 1 for even k; it is a fixed point of a disabled ring.
    function automatic logic [STAGES-1:0] reset_pattern();
        logic [STAGES-1:0] p;
        for (int k = 0; k < STAGES; k++) p[k] = (k % 2 == 0);
        return p;
    endfunction

    localparam logic [STAGES-1:0] RESET_PAT = reset_pattern();

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MEASURE,
        COMPARE,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_a_q, sel_b_q;
    logic [WIN_W-1:0]  win_q;
    logic [NUM_CH-1:0] rise;
    logic              bad_sel;

    assign bad_sel = ({1'b0, sel_a} >= NUM_RO_V) || ({1'b0, sel_b} >= NUM_RO_V);
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

    // Channel array padded to a power of two so rise[] can be indexed by any select value.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        if (i < NUM_RO) begin : g_ro
            localparam int DIV_I = BASE_DIV + i * DIV_STEP;

            logic [DIV_W-1:0]  div_q;
            logic [STAGES-1:0] ring_q;
            logic              step;
            logic              chosen;
            logic              en;

            assign step   = (div_q == DIV_W'(DIV_I - 1));
            assign chosen = (sel_a_q == SEL_W'(i)) || (sel_b_q == SEL_W'(i));
            assign en     = (state_q == MEASURE) && chosen;

            // A rising edge is a step where out is 0 now and the next out (~state[STAGES-2]) is 1.
            assign rise[i]   = step & ~ring_q[STAGES-1] & ~ring_q[STAGES-2];
            assign ro_out[i] = ring_q[STAGES-1];

            // Divider and ring state; the selected channels are re-seeded in LOAD.
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    div_q  <= '0;
                    ring_q <= RESET_PAT;
                end else if (state_q == LOAD && chosen) begin
                    div_q  <= '0;
                    ring_q <= RESET_PAT;
                end else if (step) begin
                    div_q  <= '0;
                    ring_q <= {~ring_q[STAGES-2:0], ~(en & ring_q[STAGES-1])};
                end else begin
                    div_q  <= div_q + DIV_W'(1);
                end
            end
        end else begin : g_pad
            assign rise[i] = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic.
    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = bad_sel ? DONE : LOAD;
            LOAD:    state_d = MEASURE;
            MEASURE: if (win_q == WIN_W'(WINDOW - 1)) state_d = COMPARE;
            COMPARE: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Challenge latch, window timer, edge counters and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_a_q  <= '0;
            sel_b_q  <= '0;
            win_q    <= '0;
            count_a  <= '0;
            count_b  <= '0;
            response <= 1'b0;
            tie      <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sel_a_q <= sel_a;
                        sel_b_q <= sel_b;
                        err     <= bad_sel;
                        if (bad_sel) begin
                            response <= 1'b0;
                            tie      <= 1'b0;
                            count_a  <= '0;
                            count_b  <= '0;
                        end
                    end
                end
                LOAD: begin
                    win_q    <= '0;
                    count_a  <= '0;
                    count_b  <= '0;
                    response <= 1'b0;
                    tie      <= 1'b0;
                end
                MEASURE: begin
                    win_q <= win_q + WIN_W'(1);
                    if (rise[sel_a_q] && count_a != CNT_MAX) count_a <= count_a + CNT_W'(1);
                    if (rise[sel_b_q] && count_b != CNT_MAX) count_b <= count_b + CNT_W'(1);
                end
                COMPARE: begin
                    response <= (count_a > count_b);
                    tie      <= (count_a == count_b) || (sel_a_q == sel_b_q);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ro_puf_bank.sv
// Testbench for ro_puf_bank: three small configurations (main, out-of-range index,
// narrow saturating counters) driven with directed and random challenges and compared
// against edge counts computed arithmetically from ring period and window length.
module tb_ro_puf_bank;

    localparam int STAGES   = 5;
    localparam int BASE_DIV = 2;
    localparam int DIV_STEP = 1;
    localparam int WINDOW   = 200;
    localparam int LAT      = WINDOW + 3;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Main instance: NUM_RO=4, CNT_W=16
    logic        m_start = 0, m_busy, m_done, m_resp, m_tie, m_err;
    logic [1:0]  m_sel_a = 0, m_sel_b = 0;
    logic [15:0] m_cnt_a, m_cnt_b;
    logic [3:0]  m_ro;

    ro_puf_bank #(.NUM_RO(4), .STAGES(STAGES), .BASE_DIV(BASE_DIV), .DIV_STEP(DIV_STEP),
                  .WINDOW(WINDOW), .CNT_W(16)) u_main (
        .clk(clk), .rst(rst), .start(m_start), .sel_a(m_sel_a), .sel_b(m_sel_b),
        .busy(m_busy), .done(m_done), .response(m_resp), .tie(m_tie), .err(m_err),
        .count_a(m_cnt_a), .count_b(m_cnt_b), .ro_out(m_ro));

    // Error instance: NUM_RO=3, so index 3 is out of range
    logic        e_start = 0, e_busy, e_done, e_resp, e_tie, e_err;
    logic [1:0]  e_sel_a = 0, e_sel_b = 0;
    logic [15:0] e_cnt_a, e_cnt_b;
    logic [2:0]  e_ro;

    ro_puf_bank #(.NUM_RO(3), .STAGES(STAGES), .BASE_DIV(BASE_DIV), .DIV_STEP(DIV_STEP),
                  .WINDOW(WINDOW), .CNT_W(16)) u_err (
        .clk(clk), .rst(rst), .start(e_start), .sel_a(e_sel_a), .sel_b(e_sel_b),
        .busy(e_busy), .done(e_done), .response(e_resp), .tie(e_tie), .err(e_err),
        .count_a(e_cnt_a), .count_b(e_cnt_b), .ro_out(e_ro));

    // Saturation instance: CNT_W=3
    logic        s_start = 0, s_busy, s_done, s_resp, s_tie, s_err;
    logic [1:0]  s_sel_a = 0, s_sel_b = 0;
    logic [2:0]  s_cnt_a, s_cnt_b;
    logic [3:0]  s_ro;

    ro_puf_bank #(.NUM_RO(4), .STAGES(STAGES), .BASE_DIV(BASE_DIV), .DIV_STEP(DIV_STEP),
                  .WINDOW(WINDOW), .CNT_W(3)) u_sat (
        .clk(clk), .rst(rst), .start(s_start), .sel_a(s_sel_a), .sel_b(s_sel_b),
        .busy(s_busy), .done(s_done), .response(s_resp), .tie(s_tie), .err(s_err),
        .count_a(s_cnt_a), .count_b(s_cnt_b), .ro_out(s_ro));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: full enabled-ring periods in the window, clipped to counter range.
    function automatic int exp_count(input int idx, input int cnt_w);
        int period, n, cap;
        period = 2 * STAGES * (BASE_DIV + idx * DIV_STEP);
        n      = WINDOW / period;
        cap    = (1 << cnt_w) - 1;
        return (n > cap) ? cap : n;
    endfunction

    // Issue one challenge on the main instance and check latency and results.
    task automatic run_main(input int a, input int b, input string tag);
        int k, ea, eb;
        ea = exp_count(a, 16);
        eb = exp_count(b, 16);
        @(negedge clk);
        m_sel_a = 2'(a);
        m_sel_b = 2'(b);
        m_start = 1'b1;
        @(negedge clk);
        k = 1;
        m_start = 1'b0;
        m_sel_a = 2'($urandom_range(3));
        m_sel_b = 2'($urandom_range(3));
        check({tag, "_busy_load"}, 32'(m_busy), 1);
        while (!m_done && k < LAT + 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, k, LAT);
        check({tag, "_count_a"}, 32'(m_cnt_a), ea);
        check({tag, "_count_b"}, 32'(m_cnt_b), eb);
        check({tag, "_response"}, 32'(m_resp), (ea > eb) ? 1 : 0);
        check({tag, "_tie"}, 32'(m_tie), (ea == eb || a == b) ? 1 : 0);
        check({tag, "_err"}, 32'(m_err), 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(m_done), 0);
        check({tag, "_busy_idle"}, 32'(m_busy), 0);
        check({tag, "_hold_a"}, 32'(m_cnt_a), ea);
    endtask

    initial begin
        int k, bcnt, seen;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(m_busy), 0);
        check("rst_done", 32'(m_done), 0);
        check("rst_outs", {m_resp, m_tie, m_err, s_resp, s_tie, s_err}, 0);
        check("rst_counts", 32'(m_cnt_a) | 32'(m_cnt_b), 0);
        check("rst_ro_main", 32'(m_ro), 32'hF);
        check("rst_ro_err", 32'(e_ro), 32'h7);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_ro_main", 32'(m_ro), 32'hF);

        // Directed challenges
        run_main(0, 3, "d03");
        run_main(3, 1, "d31");
        run_main(2, 2, "d22");

        // Random challenges
        for (int r = 0; r < 4; r++) begin
            run_main(int'($urandom_range(3)), int'($urandom_range(3)), $sformatf("rnd%0d", r));
        end

        // Out-of-range index on the NUM_RO=3 instance, first on sel_a then on sel_b
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            e_sel_a = (r == 0) ? 2'd3 : 2'd0;
            e_sel_b = (r == 0) ? 2'd1 : 2'd3;
            e_start = 1'b1;
            @(negedge clk);
            e_start = 1'b0;
            k = 1;
            bcnt = 0;
            seen = 0;
            while (k <= 6) begin
                if (e_busy) bcnt++;
                if (e_done && seen == 0) begin
                    seen = k;
                    check("err_flag", 32'(e_err), 1);
                    check("err_resp_tie", {e_resp, e_tie}, 0);
                    check("err_counts", 32'(e_cnt_a) | 32'(e_cnt_b), 0);
                end
                @(negedge clk);
                k++;
            end
            check("err_done_seen", 32'(seen >= 1 && seen <= 2), 1);
            check("err_busy_len", 32'(bcnt <= 2), 1);
            check("err_hold", 32'(e_err), 1);
        end

        // Valid challenge on the same instance clears err and measures normally
        @(negedge clk);
        e_sel_a = 2'd0;
        e_sel_b = 2'd2;
        e_start = 1'b1;
        @(negedge clk);
        e_start = 1'b0;
        check("err_cleared", 32'(e_err), 0);
        k = 1;
        while (!e_done && k < LAT + 20) begin
            @(negedge clk);
            k++;
        end
        check("e02_latency", k, LAT);
        check("e02_count_a", 32'(e_cnt_a), exp_count(0, 16));
        check("e02_count_b", 32'(e_cnt_b), exp_count(2, 16));
        check("e02_response", 32'(e_resp), 1);

        // Saturating counters with a second start during MEASURE
        @(negedge clk);
        s_sel_a = 2'd0;
        s_sel_b = 2'd1;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        k = 1;
        while (!s_done && k < LAT + 20) begin
            if (k == 50) begin
                s_start = 1'b1;
                s_sel_a = 2'd1;
                s_sel_b = 2'd0;
            end else begin
                s_start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        s_start = 1'b0;
        check("sat_latency", k, LAT);
        check("sat_count_a", 32'(s_cnt_a), exp_count(0, 3));
        check("sat_count_b", 32'(s_cnt_b), exp_count(1, 3));
        check("sat_response", 32'(s_resp), 1);
        check("sat_tie", 32'(s_tie), 0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (s_done || s_busy) seen = 1;
        end
        check("sat_no_rerun", seen, 0);

        // Reset in the middle of a measurement
        @(negedge clk);
        m_sel_a = 2'd0;
        m_sel_b = 2'd3;
        m_start = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy_done", {m_busy, m_done}, 0);
        check("abort_outs", {m_resp, m_tie, m_err}, 0);
        check("abort_counts", 32'(m_cnt_a) | 32'(m_cnt_b), 0);
        check("abort_ro", 32'(m_ro), 32'hF);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (LAT + 10) begin
            @(negedge clk);
            if (m_done) seen = 1;
        end
        check("abort_no_done", seen, 0);
        run_main(0, 3, "rerun03");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
